// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
// Blank masks are computed at a fixed maximum size and narrowed by each caller.
package seg_disp_pkg;

    localparam int DEFAULT_REFRESH_DIV = 100000;

    // Upper bounds for blank_mask(); NUM_DIGITS*DIGIT_W must fit in MAX_VEC_W.
    localparam int MAX_DIGITS  = 32;
    localparam int MAX_DIGIT_W = 8;
    localparam int MAX_VEC_W   = MAX_DIGITS * MAX_DIGIT_W;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    typedef logic [MAX_DIGITS-1:0] digit_mask_t;
    typedef logic [MAX_VEC_W-1:0]  digit_vec_t;

    // Bit i set when digit i and every digit above it are zero; digit 0 never set.
    function automatic digit_mask_t blank_mask(
        input digit_vec_t digits,
        input int         num_digits,
        input int         digit_w,
        input logic       enable
    );
        digit_mask_t mask;
        digit_vec_t  field_mask;
        logic        all_zero;
        mask       = '0;
        all_zero   = 1'b1;
        field_mask = (digit_vec_t'(1) << digit_w) - digit_vec_t'(1);
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < num_digits) begin
                all_zero = all_zero && (((digits >> (i * digit_w)) & field_mask) == '0);
                mask[i]  = enable && all_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_refresh_prescaler.sv
// Free-running slot prescaler: counts 0..REFRESH_DIV-1 and flags the last
// (tick) and first (slot_first) cycle of every display slot.
module seg_refresh_prescaler
    import seg_disp_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic slot_first
);

    localparam int                CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] pcnt_reg;
    logic [CNT_W-1:0] pcnt_next;

    assign tick       = (pcnt_reg == CNT_MAX);
    assign slot_first = (pcnt_reg == '0);

    always_comb begin
        pcnt_next = pcnt_reg + 1'b1;
        if (tick) begin
            pcnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_next;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode scan controller with frame-atomic data commit,
// dead time between slots, per-digit enables and leading-zero blanking.
module seg_scan_ctrl
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int DIGIT_W       = 4,
    parameter int REFRESH_DIV   = DEFAULT_REFRESH_DIV,
    parameter int BLANK_LEADING = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    input  logic                          load,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [DIGIT_W-1:0]            digit_val,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);

    localparam int                     IDX_W      = $clog2(NUM_DIGITS);
    localparam int                     VEC_W      = NUM_DIGITS * DIGIT_W;
    localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0]  ANODE_IDLE = ANODE_OFF[NUM_DIGITS-1:0];

    logic tick;
    logic slot_first;

    logic [VEC_W-1:0]      shadow_reg,      shadow_next;
    logic [VEC_W-1:0]      active_reg,      active_next;
    logic                  pending_reg,     pending_next;
    logic [IDX_W-1:0]      idx_reg,         idx_next;
    logic [DIGIT_W-1:0]    digit_val_reg,   digit_val_next;
    logic [NUM_DIGITS-1:0] anode_n_reg,     anode_n_next;
    logic                  frame_start_reg, frame_start_next;

    logic                  wrap;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [NUM_DIGITS-1:0] drive_vec;

    seg_refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .slot_first (slot_first)
    );

    // Load, frame commit and scan index. A load on the wrap tick bypasses
    // shadow so the new frame already shows it.
    always_comb begin
        wrap             = tick && (idx_reg == LAST_IDX);
        shadow_next      = shadow_reg;
        active_next      = active_reg;
        pending_next     = pending_reg;
        idx_next         = idx_reg;
        frame_start_next = wrap;

        if (load) begin
            shadow_next  = digits_in;
            pending_next = 1'b1;
        end

        if (wrap) begin
            if (load) begin
                active_next  = digits_in;
                pending_next = 1'b0;
            end else if (pending_reg) begin
                active_next  = shadow_reg;
                pending_next = 1'b0;
            end
        end

        if (tick) begin
            idx_next = wrap ? '0 : idx_reg + 1'b1;
        end
    end

    assign blank_vec = NUM_DIGITS'(blank_mask(digit_vec_t'(active_next), NUM_DIGITS,
                                              DIGIT_W, BLANK_LEADING != 0));

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_drive
        assign drive_vec[gi] = (idx_next == IDX_W'(gi)) && digit_en[gi] && !blank_vec[gi];
    end

    // The cycle after a tick is the dead cycle of the next slot.
    assign anode_n_next   = tick ? ANODE_IDLE : ~drive_vec;
    assign digit_val_next = active_next[int'(idx_next) * DIGIT_W +: DIGIT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg      <= '0;
            active_reg      <= '0;
            pending_reg     <= 1'b0;
            idx_reg         <= '0;
            digit_val_reg   <= '0;
            anode_n_reg     <= ANODE_IDLE;
            frame_start_reg <= 1'b0;
        end else begin
            shadow_reg      <= shadow_next;
            active_reg      <= active_next;
            pending_reg     <= pending_next;
            idx_reg         <= idx_next;
            digit_val_reg   <= digit_val_next;
            anode_n_reg     <= anode_n_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign digit_val   = digit_val_reg;
    assign anode_n     = anode_n_reg;
    assign digit_idx   = idx_reg;
    assign frame_start = frame_start_reg;

    // Every slot must open with all anodes released.
    a_dead_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        slot_first |-> (anode_n_reg == ANODE_IDLE));

endmodule
